// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/DM arbiter in front of a single-port fixed-latency memory
module mem_arbiter #(
  parameter int LAT        = 2,
  parameter int MAX_DM_RUN = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          dm_stall,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [3:0] LAT_C = 4'(LAT);
  localparam logic [3:0] RUN_C = 4'(MAX_DM_RUN);

  state_t     state, state_nx;
  logic [3:0] cnt, run;
  logic       if_live, dm_live, grant_if, grant_dm, done;

  // A request still high in its own ack cycle is stale and must not be re-granted.
  assign if_live  = if_req & ~if_ack;
  assign dm_live  = dm_req & ~dm_ack;
  assign grant_dm = (state == IDLE) & dm_live & ~(if_live & (run == RUN_C));
  assign grant_if = (state == IDLE) & if_live & ~grant_dm;
  assign done     = (state != IDLE) & (cnt == 4'd1);

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_dm)      state_nx = BUSY_DM;
        else if (grant_if) state_nx = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= 4'd0;
      run       <= 4'd0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      mem_cs <= grant_dm | grant_if;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;

      if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_we    <= dm_we;
        mem_wdata <= dm_wdata;
        cnt       <= LAT_C;
      end else if (grant_if) begin
        mem_addr <= if_addr;
        mem_we   <= 1'b0;
        cnt      <= LAT_C;
      end else if (state != IDLE) begin
        cnt <= cnt - 4'd1;
      end

      if (done) begin
        if (state == BUSY_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_ack <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end
      end

      // Consecutive DM wins while a fetch waits; reaching the limit forces IF next.
      if (state == IDLE) begin
        if (!if_req || grant_if)            run <= 4'd0;
        else if (grant_dm && run != RUN_C)  run <= run + 4'd1;
      end
    end
  end

endmodule
